// File: rtl/systolic_feeder_4x4.sv
// Feeder for the 4x4 systolic multiplier: buffers A then B from a word stream and drives skewed edge feeds.
// Optional FEEDER_OPCNT_EN adds a 16-bit completed-operation counter output (op_count).

module systolic_feeder_lane #(
  parameter int DATA_W = 32,
  parameter int LANE   = 0
) (
  input  logic [3:0][DATA_W-1:0] vec,
  input  logic [2:0]             t,
  output logic [DATA_W-1:0]      feed
);
  logic [3:0] k;

  // Lane LANE is delayed by LANE cycles; element k=t-LANE is live for k in 0..3.
  always_comb begin
    feed = '0;
    k    = {1'b0, t} - 4'(LANE);
    if (({1'b0, t} >= 4'(LANE)) && (k <= 4'd3)) feed = vec[k[1:0]];
  end
endmodule

module systolic_feeder_4x4 #(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] a_0,
  output logic [DATA_W-1:0] a_1,
  output logic [DATA_W-1:0] a_2,
  output logic [DATA_W-1:0] a_3,
  output logic [DATA_W-1:0] b_0,
  output logic [DATA_W-1:0] b_1,
  output logic [DATA_W-1:0] b_2,
  output logic [DATA_W-1:0] b_3,
  output logic              flag,
  output logic              busy,
  output logic              done
`ifdef FEEDER_OPCNT_EN
  ,
  output logic [15:0]       op_count
`endif
);
  localparam int NUM_LANES = 4;
  localparam int DCW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {LOAD, FEED, DRAIN, DONE} state_t;

  state_t     state;
  logic [4:0] wcnt;
  logic [2:0] t;
  logic [DCW-1:0] dcnt;

  logic [NUM_LANES-1:0][NUM_LANES-1:0][DATA_W-1:0] mat_a, mat_b, col_b;
  logic [NUM_LANES-1:0][DATA_W-1:0] a_raw, b_raw, a_q, b_q;

  logic       accept, last_word, feed_en;
  logic [2:0] t_nxt;

  assign accept    = s_valid && s_ready;
  assign last_word = accept && (wcnt == 5'd31);
  // Outputs are registered, so the feed for step t is computed one cycle early.
  assign feed_en   = last_word || ((state == FEED) && (t != 3'd6));
  assign t_nxt     = (state == FEED) ? t + 3'd1 : 3'd0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    for (genvar r = 0; r < NUM_LANES; r++) begin : g_tr
      assign col_b[g][r] = mat_b[r][g];
    end
    systolic_feeder_lane #(.DATA_W(DATA_W), .LANE(g)) u_b (
      .vec (mat_a[g]),
      .t   (t_nxt),
      .feed(b_raw[g])
    );
    systolic_feeder_lane #(.DATA_W(DATA_W), .LANE(g)) u_a (
      .vec (col_b[g]),
      .t   (t_nxt),
      .feed(a_raw[g])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (!wcnt[4]) mat_a[wcnt[3:2]][wcnt[1:0]] <= s_data;
      else          mat_b[wcnt[3:2]][wcnt[1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      wcnt    <= '0;
      t       <= '0;
      dcnt    <= '0;
      s_ready <= 1'b1;
      flag    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      a_q <= feed_en ? a_raw : '0;
      b_q <= feed_en ? b_raw : '0;
      case (state)
        LOAD: begin
          if (last_word) begin
            state   <= FEED;
            t       <= '0;
            s_ready <= 1'b0;
            flag    <= 1'b1;
            busy    <= 1'b1;
          end else if (accept) begin
            wcnt <= wcnt + 5'd1;
          end
        end
        FEED: begin
          if (t == 3'd6) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            t <= t + 3'd1;
          end
        end
        DRAIN: begin
          if (dcnt == DCW'(DRAIN_CYCLES - 1)) begin
            state <= DONE;
            flag  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state   <= LOAD;
          wcnt    <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef FEEDER_OPCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               op_count <= '0;
    else if (state == DONE) op_count <= op_count + 16'd1;
  end
`endif

  assign a_0 = a_q[0];
  assign a_1 = a_q[1];
  assign a_2 = a_q[2];
  assign a_3 = a_q[3];
  assign b_0 = b_q[0];
  assign b_1 = b_q[1];
  assign b_2 = b_q[2];
  assign b_3 = b_q[3];
endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Directed bench for systolic_feeder_4x4: load, skewed feed trace, drain, done timing, back-pressure, async reset.
module tb_systolic_feeder_4x4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, flag, busy, done;
  logic [31:0] a_0, a_1, a_2, a_3, b_0, b_1, b_2, b_3;
`ifdef FEEDER_OPCNT_EN
  logic [15:0] op_count;
`endif

  logic [3:0][31:0] av, bv;
  assign av = {a_3, a_2, a_1, a_0};
  assign bv = {b_3, b_2, b_1, b_0};

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ops = 0;
  logic [31:0] wd [32];

  systolic_feeder_4x4 dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .a_0(a_0), .a_1(a_1), .a_2(a_2), .a_3(a_3),
    .b_0(b_0), .b_1(b_1), .b_2(b_2), .b_3(b_3),
    .flag(flag), .busy(busy), .done(done)
`ifdef FEEDER_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_b(int i, int t);
    int k = t - i;
    return (k >= 0 && k <= 3) ? wd[i*4 + k] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_a(int j, int t);
    int k = t - j;
    return (k >= 0 && k <= 3) ? wd[16 + k*4 + j] : 32'h0;
  endfunction

  task automatic load(input bit gaps);
    for (int w = 0; w < 32; w++) begin
      s_valid = 1'b1;
      s_data  = wd[w];
      if (w == 31) chk("ready_before_last", {31'b0, s_ready}, 32'd1);
      tick();
      if (gaps && w != 31) begin
        s_valid = 1'b0;
        s_data  = 32'h0BAD_0BAD;
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  // Current cycle must be FEED t=0 on entry.
  task automatic run_op(input string tag, input bit hold_dead);
    if (hold_dead) begin
      s_valid = 1'b1;
      s_data  = 32'hDEADBEEF;
    end
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_b%0d_t%0d", tag, i, t), bv[i], exp_b(i, t));
        chk($sformatf("%s_a%0d_t%0d", tag, i, t), av[i], exp_a(i, t));
      end
      chk($sformatf("%s_feed_ctl_t%0d", tag, t), {29'b0, flag, busy, s_ready}, 32'h6);
      chk($sformatf("%s_feed_done_t%0d", tag, t), {31'b0, done}, 32'd0);
      if (tag == "seq" && t == 3) begin
        chk("seq_t3_b3_hand", b_3, 32'd13);
        chk("seq_t3_a3_hand", a_3, 32'd20);
        chk("seq_t3_b0_hand", b_0, 32'd4);
      end
      tick();
    end
    for (int d = 0; d < 7; d++) begin
      chk($sformatf("%s_drain_zero_%0d", tag, d), {31'b0, (|av) | (|bv)}, 32'd0);
      chk($sformatf("%s_drain_ctl_%0d", tag, d), {28'b0, done, flag, busy, s_ready}, 32'h6);
      if (d == 6) s_valid = 1'b0;
      tick();
    end
    chk($sformatf("%s_done_ctl", tag), {28'b0, done, flag, busy, s_ready}, 32'hA);
    chk($sformatf("%s_done_zero", tag), {31'b0, (|av) | (|bv)}, 32'd0);
    n_ops++;
    tick();
    chk($sformatf("%s_load_ctl", tag), {28'b0, done, flag, busy, s_ready}, 32'h1);
`ifdef FEEDER_OPCNT_EN
    chk($sformatf("%s_op_count", tag), {16'b0, op_count}, n_ops);
`endif
  endtask

  initial begin
    #12;
    chk("rst_ctl_async", {29'b0, flag, busy, done}, 32'h0);
    chk("rst_feeds", {31'b0, (|av) | (|bv)}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_ctl", {28'b0, done, flag, busy, s_ready}, 32'h1);
`ifdef FEEDER_OPCNT_EN
    chk("post_rst_op_count", {16'b0, op_count}, 32'd0);
`endif

    // Identity x identity, continuous load.
    for (int w = 0; w < 32; w++) wd[w] = ((w % 16) % 5 == 0) ? 32'd1 : 32'd0;
    load(1'b0);
    run_op("ident", 1'b0);

    // A[i][j]=4i+j+1, B[i][j]=16+4i+j+1 (both equal word index+1); toggled s_valid, then junk held high.
    for (int w = 0; w < 32; w++) wd[w] = w + 1;
    load(1'b1);
    run_op("seq", 1'b1);

    // Full-width patterns; a correct word count after the held-valid run keeps this aligned.
    for (int w = 0; w < 32; w++) wd[w] = 32'h8000_0000 ^ (w * 32'h0101_0101) ^ 32'h00F0_0F0F;
    load(1'b0);
    run_op("wide", 1'b0);

    // Reset pulsed at FEED t=3.
    for (int w = 0; w < 32; w++) wd[w] = 32'hC000_0000 + w * 7;
    load(1'b0);
    tick(); tick(); tick();
    chk("pre_rst_b0_t3", b_0, wd[3]);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctl", {28'b0, done, flag, busy, s_ready}, 32'h1);
    chk("midrst_feeds", {31'b0, (|av) | (|bv)}, 32'd0);
`ifdef FEEDER_OPCNT_EN
    chk("midrst_op_count", {16'b0, op_count}, 32'd0);
    n_ops = 0;
`endif
    #10 rst = 1'b1;
    tick();
    chk("after_midrst_ctl", {28'b0, done, flag, busy, s_ready}, 32'h1);
    for (int w = 0; w < 32; w++) wd[w] = 32'h1234_0000 + w * 32'h0001_0011;
    load(1'b0);
    run_op("reload", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
